// File: rtl/pll_reset_ctrl.sv
// PLL bring-up and staggered per-domain reset release on the reference clock.
// Optional saturating retry counter port: define PLL_RETRY_CNT_EN.
module pll_reset_ctrl #(
    parameter int ARESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT   = 65535,
    parameter int STABLE_CYCLES  = 1024,
    parameter int NUM_DOMAINS    = 4,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   sw_rst_req,
    output logic                   pll_areset,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic                   sys_ready,
    output logic                   timeout_pulse,
`ifdef PLL_RETRY_CNT_EN
    output logic                   lock_lost,
    output logic [7:0]             retry_cnt
`else
    output logic                   lock_lost
`endif
);

    localparam int M1   = (ARESET_CYCLES > LOCK_TIMEOUT) ? ARESET_CYCLES : LOCK_TIMEOUT;
    localparam int M2   = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
    localparam int MAXC = (M1 > M2) ? M1 : M2;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = $clog2(NUM_DOMAINS) + 1;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN
    } state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [IW-1:0]          idx, idx_n;
    logic                   locked_m, locked_s;
    logic                   areset_n, ready_n, tp_n, ll_n;
    logic [NUM_DOMAINS-1:0] dom_n;
    logic                   abort_lock;

    assign abort_lock = !locked_s &&
                        (state == STABLE || state == RELEASE || state == RUN);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        areset_n = pll_areset;
        dom_n    = dom_rst_n;
        ready_n  = sys_ready;
        tp_n     = 1'b0;
        ll_n     = 1'b0;
        // A soft request and a lock drop in the same cycle collapse into one abort
        if (sw_rst_req || abort_lock) begin
            state_n  = PLL_RST;
            cnt_n    = '0;
            areset_n = 1'b1;
            dom_n    = '0;
            ready_n  = 1'b0;
            ll_n     = abort_lock;
        end else begin
            unique case (state)
                PLL_RST: begin
                    areset_n = 1'b1;
                    if (cnt == CW'(ARESET_CYCLES - 1)) begin
                        state_n  = WAIT_LOCK;
                        cnt_n    = '0;
                        areset_n = 1'b0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_n = STABLE;
                        cnt_n   = '0;
                    end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                        state_n  = PLL_RST;
                        cnt_n    = '0;
                        areset_n = 1'b1;
                        tp_n     = 1'b1;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                STABLE: begin
                    if (cnt == CW'(STABLE_CYCLES - 1)) begin
                        state_n = RELEASE;
                        cnt_n   = '0;
                        idx_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt == CW'(STAGGER_CYCLES - 1)) begin
                        cnt_n = '0;
                        idx_n = idx + IW'(1);
                        for (int i = 0; i < NUM_DOMAINS; i++) begin
                            if (idx == IW'(i)) dom_n[i] = 1'b1;
                        end
                        if (idx == IW'(NUM_DOMAINS - 1)) begin
                            state_n = RUN;
                            ready_n = 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                RUN: begin
                    state_n = RUN;
                end
                default: begin
                    state_n  = PLL_RST;
                    cnt_n    = '0;
                    areset_n = 1'b1;
                    dom_n    = '0;
                    ready_n  = 1'b0;
                end
            endcase
        end
    end

`ifdef PLL_RETRY_CNT_EN
    logic [7:0] retry_n;

    always_comb begin
        retry_n = retry_cnt;
        if ((tp_n || ll_n) && retry_cnt != 8'hff) retry_n = retry_cnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retry_cnt <= '0;
        else        retry_cnt <= retry_n;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_m      <= 1'b0;
            locked_s      <= 1'b0;
            state         <= PLL_RST;
            cnt           <= '0;
            idx           <= '0;
            pll_areset    <= 1'b1;
            dom_rst_n     <= '0;
            sys_ready     <= 1'b0;
            timeout_pulse <= 1'b0;
            lock_lost     <= 1'b0;
        end else begin
            locked_m      <= pll_locked;
            locked_s      <= locked_m;
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            pll_areset    <= areset_n;
            dom_rst_n     <= dom_n;
            sys_ready     <= ready_n;
            timeout_pulse <= tp_n;
            lock_lost     <= ll_n;
        end
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with small timing parameters.
// Retry counter checks run only when PLL_RETRY_CNT_EN is defined.
module tb_pll_reset_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       pll_areset;
    logic [2:0] dom_rst_n;
    logic       sys_ready;
    logic       timeout_pulse;
    logic       lock_lost;
`ifdef PLL_RETRY_CNT_EN
    logic [7:0] retry_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int t      = 0;

    always #5 clk = ~clk;

    pll_reset_ctrl #(
        .ARESET_CYCLES (4),
        .LOCK_TIMEOUT  (32),
        .STABLE_CYCLES (8),
        .NUM_DOMAINS   (3),
        .STAGGER_CYCLES(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .sw_rst_req   (sw_rst_req),
        .pll_areset   (pll_areset),
        .dom_rst_n    (dom_rst_n),
        .sys_ready    (sys_ready),
        .timeout_pulse(timeout_pulse),
`ifdef PLL_RETRY_CNT_EN
        .lock_lost    (lock_lost),
        .retry_cnt    (retry_cnt)
`else
        .lock_lost    (lock_lost)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // t counts falling edges since the falling edge that released rst_n
    task automatic go(input int k);
        while (t < k) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
    endtask

    initial begin
        // 1: lock held from reset release
        pll_locked = 1'b1;
        do_reset();
        chk("rst_areset", 32'(pll_areset), 1);
        chk("rst_dom", 32'(dom_rst_n), 0);
        chk("rst_ready", 32'(sys_ready), 0);
        chk("rst_tp", 32'(timeout_pulse), 0);
        chk("rst_ll", 32'(lock_lost), 0);
        go(3);  chk("t1_areset_hi", 32'(pll_areset), 1);
        go(4);  chk("t1_areset_lo", 32'(pll_areset), 0);
        go(14); chk("t1_dom_000", 32'(dom_rst_n), 0);
        go(15); chk("t1_dom_001", 32'(dom_rst_n), 1);
        go(16); chk("t1_dom_001b", 32'(dom_rst_n), 1);
        go(17); chk("t1_dom_011", 32'(dom_rst_n), 3);
        go(18); chk("t1_ready_lo", 32'(sys_ready), 0);
        go(19); chk("t1_dom_111", 32'(dom_rst_n), 7);
                chk("t1_ready_hi", 32'(sys_ready), 1);

        // 3: lock drops for 3 cycles in RUN
        go(20); pll_locked = 1'b0;
        go(22); chk("t3_dom_hold", 32'(dom_rst_n), 7);
                chk("t3_ll_pre", 32'(lock_lost), 0);
        go(23); chk("t3_dom_abort", 32'(dom_rst_n), 0);
                chk("t3_ready_abort", 32'(sys_ready), 0);
                chk("t3_ll_pulse", 32'(lock_lost), 1);
                chk("t3_areset_abort", 32'(pll_areset), 1);
                pll_locked = 1'b1;
        go(24); chk("t3_ll_end", 32'(lock_lost), 0);
        go(26); chk("t3_areset_hi", 32'(pll_areset), 1);
        go(27); chk("t3_areset_lo", 32'(pll_areset), 0);
        go(37); chk("t3_dom_000", 32'(dom_rst_n), 0);
        go(38); chk("t3_dom_001", 32'(dom_rst_n), 1);
        go(42); chk("t3_dom_111", 32'(dom_rst_n), 7);
                chk("t3_ready", 32'(sys_ready), 1);

        // async reset mid-RUN, then 2: no lock at all
        pll_locked = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_dom", 32'(dom_rst_n), 0);
        chk("async_ready", 32'(sys_ready), 0);
        chk("async_areset", 32'(pll_areset), 1);
        do_reset();
        go(35); chk("t2_areset_lo", 32'(pll_areset), 0);
                chk("t2_tp_pre", 32'(timeout_pulse), 0);
        go(36); chk("t2_tp", 32'(timeout_pulse), 1);
                chk("t2_areset_re", 32'(pll_areset), 1);
                chk("t2_dom", 32'(dom_rst_n), 0);
        go(37); chk("t2_tp_end", 32'(timeout_pulse), 0);
        go(39); chk("t2_areset_hi", 32'(pll_areset), 1);
        go(40); chk("t2_areset_lo2", 32'(pll_areset), 0);
        go(71); chk("t2_tp2_pre", 32'(timeout_pulse), 0);
        go(72); chk("t2_tp2", 32'(timeout_pulse), 1);
                chk("t2_dom2", 32'(dom_rst_n), 0);
                chk("t2_ll", 32'(lock_lost), 0);

        // 4: lock drops while STABLE counter is at 5
        pll_locked = 1'b1;
        do_reset();
        go(8);  pll_locked = 1'b0;
        go(10); chk("t4_ll_pre", 32'(lock_lost), 0);
                chk("t4_areset_pre", 32'(pll_areset), 0);
        go(11); chk("t4_ll", 32'(lock_lost), 1);
                chk("t4_areset", 32'(pll_areset), 1);
                pll_locked = 1'b1;
        go(12); chk("t4_ll_end", 32'(lock_lost), 0);
        go(15); chk("t4_dom_a", 32'(dom_rst_n), 0);
        go(19); chk("t4_dom_b", 32'(dom_rst_n), 0);

        // 5: soft request in RELEASE, then again in PLL_RST at cnt=2
        do_reset();
        go(15); chk("t5_dom_001", 32'(dom_rst_n), 1);
        go(16); sw_rst_req = 1'b1;
        go(17); sw_rst_req = 1'b0;
                chk("t5_dom_abort", 32'(dom_rst_n), 0);
                chk("t5_ll", 32'(lock_lost), 0);
                chk("t5_areset", 32'(pll_areset), 1);
        go(19); sw_rst_req = 1'b1;
        go(20); sw_rst_req = 1'b0;
                chk("t5_areset_req", 32'(pll_areset), 1);
        go(21); chk("t5_areset_ext", 32'(pll_areset), 1);
        go(23); chk("t5_areset_last", 32'(pll_areset), 1);
        go(24); chk("t5_areset_lo", 32'(pll_areset), 0);
        go(35); chk("t5_dom_rel", 32'(dom_rst_n), 1);
        go(39); chk("t5_ready", 32'(sys_ready), 1);

`ifdef PLL_RETRY_CNT_EN
        // 6: retry counter
        pll_locked = 1'b0;
        do_reset();
        chk("t6_retry_rst", 32'(retry_cnt), 0);
        go(36);  chk("t6_retry_1", 32'(retry_cnt), 1);
        go(108); chk("t6_retry_3", 32'(retry_cnt), 3);
                 pll_locked = 1'b1;
        go(130); chk("t6_retry_run", 32'(retry_cnt), 3);
                 chk("t6_ready", 32'(sys_ready), 1);
                 pll_locked = 1'b0;
        go(130 + 300 * 36 + 50);
                 chk("t6_retry_sat", 32'(retry_cnt), 255);
        rst_n = 1'b0;
        #1;
        chk("t6_retry_clr", 32'(retry_cnt), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
